// File: rtl/dmem_arb.sv
// Two-port arbiter that owns the 256x32 data memory: clears it after reset,
// then round-robins CPU (A) and debug-loader (B) accesses and mirrors IO_ADDR writes.

module dmem_arb_rdport (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en_i,
    input  logic [31:0] rd_data_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);
    logic        rvalid_q;
    logic [31:0] rdata_q;

    // rdata is sticky: it only changes on this port's own granted read
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_en_i;
            if (rd_en_i) rdata_q <= rd_data_i;
        end
    end

    assign rvalid_o = rvalid_q & ~rst;
    assign rdata_o  = rst ? '0 : rdata_q;
endmodule

module dmem_arb #(
    parameter logic [7:0] IO_ADDR = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [7:0]  a_addr,
    input  logic [31:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [7:0]  b_addr,
    input  logic [31:0] b_wdata,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [31:0] a_rdata,
    output logic [31:0] b_rdata,
    output logic        init_done,
    output logic        io_write,
    output logic [31:0] io_data
);
    localparam int NP = 2;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               last_q, last_d;   // 1: B was granted most recently
    logic               io_write_q;
    logic [31:0]        io_data_q;
    req_t [NP-1:0]      rq;
    logic [NP-1:0]      gnt;
    req_t               sel;
    logic               sel_vld;
    logic               io_hit;
    logic [31:0]        mem_rd;
    logic [NP-1:0]      rvalid;
    logic [NP-1:0][31:0] rdata;
    logic [31:0]        mem [256];

    assign rq[0] = {a_req, a_we, a_addr, a_wdata};
    assign rq[1] = {b_req, b_we, b_addr, b_wdata};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt     = '0;
        case (state_q)
            CLEAR: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) state_d = RUN;
            end
            RUN: begin
                if (rq[0].req && rq[1].req) gnt = last_q ? 2'b01 : 2'b10;
                else                        gnt = {rq[1].req, rq[0].req};
                if (gnt[0])      last_d = 1'b0;
                else if (gnt[1]) last_d = 1'b1;
            end
            default: state_d = CLEAR;
        endcase
        if (rst) gnt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign sel     = gnt[1] ? rq[1] : rq[0];
    assign sel_vld = |gnt;
    assign io_hit  = sel_vld && sel.we && (sel.addr == IO_ADDR);
    assign mem_rd  = mem[sel.addr];

    // single write port shared between the clear sweep and granted writes
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR)     mem[cnt_q]    <= '0;
            else if (sel_vld && sel.we) mem[sel.addr] <= sel.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io_write_q <= 1'b0;
            io_data_q  <= '0;
        end else begin
            io_write_q <= io_hit;
            io_data_q  <= io_hit ? sel.wdata : '0;
        end
    end

    for (genvar p = 0; p < NP; p++) begin : g_rd
        dmem_arb_rdport u_rd (
            .clk       (clk),
            .rst       (rst),
            .rd_en_i   (gnt[p] & ~rq[p].we),
            .rd_data_i (mem_rd),
            .rvalid_o  (rvalid[p]),
            .rdata_o   (rdata[p])
        );
    end

    assign a_gnt     = gnt[0];
    assign b_gnt     = gnt[1];
    assign a_rvalid  = rvalid[0];
    assign b_rvalid  = rvalid[1];
    assign a_rdata   = rdata[0];
    assign b_rdata   = rdata[1];
    assign init_done = (state_q == RUN) && !rst;
    assign io_write  = io_write_q & ~rst;
    assign io_data   = rst ? '0 : io_data_q;
endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb: expected read/IO results are queued at grant
// time with the cycle they are due, and matched when the DUT strobes them.

module tb_dmem_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, init_done, io_write;
    logic [31:0] a_rdata, b_rdata, io_data;

    typedef struct {
        logic [31:0] d;
        int          due;
    } sb_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    sb_t         exp_a[$], exp_b[$], exp_io[$];
    sb_t         sa, sb, si;
    logic [31:0] model [256];
    bit          last_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arb #(.IO_ADDR(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata), .init_done(init_done),
        .io_write(io_write), .io_data(io_data)
    );

    // scoreboard: every strobe must match the queue head on its due cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (a_rvalid) begin
                checks++;
                if (exp_a.size() == 0) begin
                    failures++; $display("FAIL a_rvalid_unexpected: rdata=%h", a_rdata);
                end else begin
                    sa = exp_a.pop_front();
                    if (a_rdata !== sa.d || cyc != sa.due) begin
                        failures++;
                        $display("FAIL a_read: got %h@%0d expected %h@%0d", a_rdata, cyc, sa.d, sa.due);
                    end
                end
            end else if (exp_a.size() != 0 && exp_a[0].due <= cyc) begin
                checks++; failures++; sa = exp_a.pop_front();
                $display("FAIL a_rvalid_missing: expected %h@%0d", sa.d, sa.due);
            end
            if (b_rvalid) begin
                checks++;
                if (exp_b.size() == 0) begin
                    failures++; $display("FAIL b_rvalid_unexpected: rdata=%h", b_rdata);
                end else begin
                    sb = exp_b.pop_front();
                    if (b_rdata !== sb.d || cyc != sb.due) begin
                        failures++;
                        $display("FAIL b_read: got %h@%0d expected %h@%0d", b_rdata, cyc, sb.d, sb.due);
                    end
                end
            end else if (exp_b.size() != 0 && exp_b[0].due <= cyc) begin
                checks++; failures++; sb = exp_b.pop_front();
                $display("FAIL b_rvalid_missing: expected %h@%0d", sb.d, sb.due);
            end
            if (io_write) begin
                checks++;
                if (exp_io.size() == 0) begin
                    failures++; $display("FAIL io_unexpected: io_data=%h", io_data);
                end else begin
                    si = exp_io.pop_front();
                    if (io_data !== si.d || cyc != si.due) begin
                        failures++;
                        $display("FAIL io_pulse: got %h@%0d expected %h@%0d", io_data, cyc, si.d, si.due);
                    end
                end
            end else begin
                if (exp_io.size() != 0 && exp_io[0].due <= cyc) begin
                    checks++; failures++; si = exp_io.pop_front();
                    $display("FAIL io_missing: expected %h@%0d", si.d, si.due);
                end
                if (io_data !== 32'h0) begin
                    checks++; failures++;
                    $display("FAIL io_data_idle: got %h expected 0", io_data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [7:0] addr, input logic [31:0] wd);
        a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [7:0] addr, input logic [31:0] wd);
        b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    endtask

    // called at the negedge of a cycle in which the bench expects a grant
    task automatic note_grant(input bit port, input logic we, input logic [7:0] addr, input logic [31:0] wd);
        if (we) begin
            model[addr] = wd;
            if (addr == 8'hFF) exp_io.push_back('{wd, cyc + 1});
        end else if (port == 1'b0) exp_a.push_back('{model[addr], cyc + 1});
        else                       exp_b.push_back('{model[addr], cyc + 1});
        last_b = port;
    endtask

    task automatic bench_reset_state();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        last_b = 1'b1;
        exp_a.delete(); exp_b.delete(); exp_io.delete();
    endtask

    task automatic test_reset();
        bit bad = 0;
        drive_a(1'b1, 1'b0, 8'h10, 32'h0);
        drive_b(1'b0, 1'b0, 8'h00, 32'h0);
        rst = 1'b1;
        bench_reset_state();
        step(); step();
        @(negedge clk);
        checks++;
        if ({init_done, a_gnt, b_gnt, a_rvalid, b_rvalid, io_write} !== 6'b0 ||
            a_rdata !== 32'h0 || b_rdata !== 32'h0 || io_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: init=%b gnt=%b%b rv=%b%b io=%b rd=%h/%h iod=%h expected all 0",
                     init_done, a_gnt, b_gnt, a_rvalid, b_rvalid, io_write, a_rdata, b_rdata, io_data);
        end
        step(); rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (init_done !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL clear_phase: init/gnt seen high, expected 0 for 256 cycles"); end
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            failures++;
            $display("FAIL first_run_cycle: init=%b a_gnt=%b b_gnt=%b expected 1 1 0", init_done, a_gnt, b_gnt);
        end
        note_grant(1'b0, 1'b0, 8'h10, 32'h0);
        step(); drive_a(1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin
            failures++; $display("FAIL init_read: rvalid=%b rdata=%h expected 1 00000000", a_rvalid, a_rdata);
        end
        step();
    endtask

    task automatic test_write_read();
        drive_a(1'b1, 1'b1, 8'h20, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            failures++; $display("FAIL wr_grant: a=%b b=%b expected 1 0", a_gnt, b_gnt);
        end
        note_grant(1'b0, 1'b1, 8'h20, 32'hDEADBEEF);
        step();
        drive_a(1'b0, 1'b0, 8'h00, 32'h0);
        drive_b(1'b1, 1'b0, 8'h20, 32'h0);
        @(negedge clk);
        checks++;
        if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
            failures++; $display("FAIL rd_grant_b: a=%b b=%b expected 0 1", a_gnt, b_gnt);
        end
        note_grant(1'b1, 1'b0, 8'h20, 32'h0);
        step(); drive_b(1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        checks++;
        if (b_rvalid !== 1'b1 || b_rdata !== 32'hDEADBEEF || a_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_then_rd: b_rv=%b b_rd=%h a_rv=%b expected 1 deadbeef 0", b_rvalid, b_rdata, a_rvalid);
        end
        step();
    endtask

    task automatic test_round_robin();
        bit exp_b_port;
        bit bad = 0;
        rst = 1'b1;
        bench_reset_state();
        drive_a(1'b1, 1'b0, 8'h30, 32'h0);
        drive_b(1'b1, 1'b0, 8'h31, 32'h0);
        step(); step(); rst = 1'b0;
        repeat (256) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_b_port = ~last_b;
            if (i == 0) begin
                checks++;
                if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
                    failures++; $display("FAIL rr_first: a=%b b=%b expected 1 0", a_gnt, b_gnt);
                end
            end
            if (a_gnt !== !exp_b_port || b_gnt !== exp_b_port) bad = 1;
            note_grant(exp_b_port, 1'b0, exp_b_port ? 8'h31 : 8'h30, 32'h0);
            step();
        end
        checks++;
        if (bad) begin failures++; $display("FAIL rr_alternate: grants did not alternate A,B,A,B"); end
        drive_a(1'b0, 1'b0, 8'h00, 32'h0);
        drive_b(1'b0, 1'b0, 8'h00, 32'h0);
        step(); step(); step();
        drive_a(1'b1, 1'b0, 8'h30, 32'h0);
        drive_b(1'b1, 1'b0, 8'h31, 32'h0);
        @(negedge clk);
        exp_b_port = ~last_b;
        checks++;
        if (a_gnt !== !exp_b_port || b_gnt !== exp_b_port) begin
            failures++; $display("FAIL rr_after_idle: a=%b b=%b expected %b %b", a_gnt, b_gnt, !exp_b_port, exp_b_port);
        end
        note_grant(exp_b_port, 1'b0, exp_b_port ? 8'h31 : 8'h30, 32'h0);
        step();
        drive_a(1'b0, 1'b0, 8'h00, 32'h0);
        drive_b(1'b0, 1'b0, 8'h00, 32'h0);
        step(); step();
    endtask

    task automatic test_io();
        drive_b(1'b1, 1'b1, 8'hFF, 32'h12345678);
        @(negedge clk);
        checks++;
        if (b_gnt !== 1'b1) begin failures++; $display("FAIL io_grant: b_gnt=%b expected 1", b_gnt); end
        note_grant(1'b1, 1'b1, 8'hFF, 32'h12345678);
        step(); drive_b(1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        checks++;
        if (io_write !== 1'b1 || io_data !== 32'h12345678) begin
            failures++; $display("FAIL io_strobe: io_write=%b io_data=%h expected 1 12345678", io_write, io_data);
        end
        step();
        drive_a(1'b1, 1'b0, 8'hFF, 32'h0);
        @(negedge clk);
        checks++;
        if (io_write !== 1'b0 || io_data !== 32'h0 || a_gnt !== 1'b1) begin
            failures++; $display("FAIL io_end: io_write=%b io_data=%h a_gnt=%b expected 0 0 1", io_write, io_data, a_gnt);
        end
        note_grant(1'b0, 1'b0, 8'hFF, 32'h0);
        step(); drive_a(1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        checks++;
        if (a_rdata !== 32'h12345678 || io_write !== 1'b0) begin
            failures++; $display("FAIL io_readback: a_rdata=%h io_write=%b expected 12345678 0", a_rdata, io_write);
        end
        step();
    endtask

    task automatic test_back_to_back();
        bit bad = 0;
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 1'b1, 8'h50 + 8'(i), $urandom);
            @(negedge clk);
            if (a_gnt !== 1'b1) bad = 1;
            note_grant(1'b0, 1'b1, a_addr, a_wdata);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 1'b0, 8'h50 + 8'(i), 32'h0);
            @(negedge clk);
            if (a_gnt !== 1'b1) bad = 1;
            note_grant(1'b0, 1'b0, a_addr, 32'h0);
            step();
        end
        checks++;
        if (bad) begin failures++; $display("FAIL b2b_grant: a_gnt dropped during back-to-back accesses"); end
        drive_a(1'b0, 1'b0, 8'h00, 32'h0);
        step(); step();
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0 || a_rdata !== model[8'h53]) begin
            failures++; $display("FAIL rdata_hold: rvalid=%b rdata=%h expected 0 %h", a_rvalid, a_rdata, model[8'h53]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bit bad = 0;
        drive_a(1'b1, 1'b0, 8'h20, 32'h0);
        @(negedge clk);
        checks++;
        if (a_gnt !== 1'b1) begin failures++; $display("FAIL mid_grant: a_gnt=%b expected 1", a_gnt); end
        note_grant(1'b0, 1'b0, 8'h20, 32'h0);
        step();
        rst = 1'b1;
        bench_reset_state();
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b0 || a_rdata !== 32'h0 || init_done !== 1'b0 || a_gnt !== 1'b0) begin
            failures++;
            $display("FAIL rst_run: rv=%b rd=%h init=%b gnt=%b expected 0 0 0 0", a_rvalid, a_rdata, init_done, a_gnt);
        end
        step(); rst = 1'b0;
        repeat (100) step();
        rst = 1'b1;
        step(); rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (init_done !== 1'b0 || a_gnt !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL rst_clear_restart: init/gnt high before 256 clear cycles"); end
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1 || a_gnt !== 1'b1) begin
            failures++; $display("FAIL rst_run_again: init=%b a_gnt=%b expected 1 1", init_done, a_gnt);
        end
        note_grant(1'b0, 1'b0, 8'h20, 32'h0);
        step(); drive_a(1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin
            failures++; $display("FAIL rst_cleared_data: rv=%b rdata=%h expected 1 00000000", a_rvalid, a_rdata);
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        drive_a(1'b0, 1'b0, 8'h00, 32'h0);
        drive_b(1'b0, 1'b0, 8'h00, 32'h0);
        test_reset();
        test_write_read();
        test_round_robin();
        test_io();
        test_back_to_back();
        test_reset_mid();
        step(); step(); step();
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0 || exp_io.size() != 0) begin
            failures++;
            $display("FAIL drain: pending a=%0d b=%0d io=%0d expected 0 0 0", exp_a.size(), exp_b.size(), exp_io.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
